// File: rtl/data_mem_access.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_mem_access
// Sequences one CPU load/store at a time onto a single-port word memory with a
// fixed read latency. Bad requests (misaligned or past the end of memory) are
// answered with a fault response and never reach the memory.
//
// Ports
//   Clock, Reset_N      : clock, asynchronous active-low reset
//   Req_Valid/Write     : request present / 1 = store, 0 = load
//   Req_Addr, Req_WData : byte address, store data
//   Req_Ready           : request can be accepted this cycle (IDLE only)
//   Rsp_Valid           : one-cycle completion pulse
//   Rsp_RData/Rsp_Fault : load result / access rejected (valid with Rsp_Valid)
//   Mem_Addr            : word address to memory
//   Mem_En_W/Mem_En_R   : memory write / read enable (one cycle each)
//   Mem_Data_W          : memory write data
//   Mem_Data_R          : memory read data, valid READ_LATENCY cycles after
//                         the read cycle begins
// -----------------------------------------------------------------------------
module data_mem_access #(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        Clock,
  input  logic        Reset_N,
  input  logic        Req_Valid,
  input  logic        Req_Write,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Req_Ready,
  output logic        Rsp_Valid,
  output logic [31:0] Rsp_RData,
  output logic        Rsp_Fault,
  output logic [29:0] Mem_Addr,
  output logic        Mem_En_W,
  output logic        Mem_En_R,
  output logic [31:0] Mem_Data_W,
  input  logic [31:0] Mem_Data_R
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned CNT_W   = 2;

  // Latency clamped into the supported 1..3 range.
  localparam int unsigned LAT = (READ_LATENCY < 1) ? 1 :
                                (READ_LATENCY > 3) ? 3 : READ_LATENCY;
  // Cycles spent in WAIT between the read cycle and the capture edge.
  localparam int unsigned WAIT_CYCLES = LAT - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_fault_q, rsp_fault_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [WADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                 mem_en_w_q, mem_en_w_d;
  logic                 mem_en_r_q, mem_en_r_d;
  logic [DATA_W-1:0]    mem_data_w_q, mem_data_w_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;

  logic [WADDR_W-1:0]   req_word_c;
  logic                 req_misaligned_c;
  logic                 req_oob_c;
  logic                 req_fault_c;
  logic                 accept_c;

  // Request decode: word address and legality.
  assign req_word_c       = Req_Addr[ADDR_W-1:2];
  assign req_misaligned_c = |Req_Addr[1:0];
  assign req_oob_c        = ({2'b00, req_word_c} >= MEM_WORDS);
  assign req_fault_c      = req_misaligned_c | req_oob_c;
  assign accept_c         = Req_Valid & (state_q == IDLE);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_data_w_d = mem_data_w_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_fault_d  = 1'b0;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (req_fault_c) begin
            // Rejected: straight to the response, memory untouched.
            state_d     = RESP;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = '0;
          end else if (Req_Write) begin
            state_d      = WRITE;
            mem_addr_d   = req_word_c;
            mem_data_w_d = Req_WData;
          end else begin
            state_d    = READ;
            mem_addr_d = req_word_c;
          end
        end
      end

      WRITE: begin
        state_d = RESP;
      end

      READ: begin
        if (WAIT_CYCLES == 0) begin
          // Single-cycle memory: data is valid during the read cycle.
          state_d     = RESP;
          rsp_rdata_d = Mem_Data_R;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(WAIT_CYCLES - 1);
        end
      end

      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d     = RESP;
          rsp_rdata_d = Mem_Data_R;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are registered copies of the state being entered.
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_en_w_d  = (state_d == WRITE);
    mem_en_r_d  = (state_d == READ);
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_fault_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_addr_q   <= '0;
      mem_en_w_q   <= 1'b0;
      mem_en_r_q   <= 1'b0;
      mem_data_w_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_fault_q  <= rsp_fault_d;
      rsp_rdata_q  <= rsp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_en_w_q   <= mem_en_w_d;
      mem_en_r_q   <= mem_en_r_d;
      mem_data_w_q <= mem_data_w_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign Req_Ready  = ready_q;
  assign Rsp_Valid  = rsp_valid_q;
  assign Rsp_Fault  = rsp_fault_q;
  assign Rsp_RData  = rsp_rdata_q;
  assign Mem_Addr   = mem_addr_q;
  assign Mem_En_W   = mem_en_w_q;
  assign Mem_En_R   = mem_en_r_q;
  assign Mem_Data_W = mem_data_w_q;

endmodule

// File: doc/data_mem_access.md
DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 4096, meaning the number of 32-bit words in the attached data memory (16KB).
REQ-002 The block SHALL have parameter READ_LATENCY, default 1, meaning the number of cycles from Mem_En_R high to valid Mem_Data_R; the legal range is 1..3.
REQ-003 The block SHALL have port Clock, input, width 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset_N, input, width 1: reset is asynchronous and active-low.
REQ-005 The block SHALL have port Req_Valid, input, width 1, meaning a CPU access request is present.
REQ-006 The block SHALL have port Req_Write, input, width 1: 1 = store, 0 = load.
REQ-007 The block SHALL have port Req_Addr, input, width 32, carrying the byte address.
REQ-008 The block SHALL have port Req_WData, input, width 32, carrying the store data.
REQ-009 The block SHALL have port Req_Ready, output, width 1, meaning the block can accept a request this cycle.
REQ-010 The block SHALL have port Rsp_Valid, output, width 1, a one-cycle completion pulse.
REQ-011 The block SHALL have port Rsp_RData, output, width 32, carrying the load result.
REQ-012 The block SHALL have port Rsp_Fault, output, width 1, meaning the access was rejected; it is valid with Rsp_Valid.
REQ-013 The block SHALL have port Mem_Addr, output, width 30, carrying the word address to memory.
REQ-014 The block SHALL have port Mem_En_W, output, width 1, the memory write enable.
REQ-015 The block SHALL have port Mem_En_R, output, width 1, the memory read enable.
REQ-016 The block SHALL have port Mem_Data_W, output, width 32, carrying the memory write data.
REQ-017 The block SHALL have port Mem_Data_R, input, width 32, carrying the memory read data.

Function
REQ-018 The block SHALL implement the FSM states IDLE, WRITE, READ, WAIT and RESP.
REQ-019 Req_Ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on a rising edge with Req_Valid=1 and Req_Ready=1; Req_Valid in other states SHALL be ignored.
REQ-021 A request SHALL fault when Req_Addr[1:0]!=0 or Req_Addr[31:2]>=MEM_WORDS.
REQ-022 On a faulting accept, the FSM SHALL go IDLE->RESP; no memory enable is asserted, and in RESP Rsp_Fault=1 and Rsp_RData=0.
REQ-023 On a legal store accept at edge T, the FSM SHALL enter WRITE.
REQ-024 In WRITE, for exactly one cycle: Mem_En_W=1, Mem_Addr=Req_Addr[31:2], Mem_Data_W=Req_WData, all registered at T; the FSM then enters RESP.
REQ-025 On a legal load accept, the FSM SHALL enter READ.
REQ-026 In READ, for exactly one cycle: Mem_En_R=1 and Mem_Addr=Req_Addr[31:2]; the FSM then enters WAIT.
REQ-027 WAIT SHALL last READ_LATENCY-1 cycles (zero cycles when READ_LATENCY=1), then RESP.
REQ-028 Mem_Data_R SHALL be captured into Rsp_RData on the edge exactly READ_LATENCY cycles after the READ cycle began; this edge is the entry to RESP.
REQ-029 Total latency from the accept edge to Rsp_Valid SHALL be: store 2 cycles, load READ_LATENCY+1 cycles, fault 1 cycle.
REQ-030 RESP SHALL last one cycle, with Rsp_Valid=1 and Rsp_Fault=0 for legal accesses, then return to IDLE; the next accept is possible on the following edge.
REQ-031 Rsp_RData SHALL hold its value until the next load completion or fault, and SHALL be unchanged by store completions.
REQ-032 Mem_En_W and Mem_En_R SHALL never be high together and SHALL each be high exactly one cycle per legal accepted access of their type.
REQ-033 Mem_Addr and Mem_Data_W SHALL hold their last driven values when no enable is asserted.
REQ-034 Rsp_Valid SHALL have no backpressure and SHALL pulse exactly once per accepted request.
REQ-035 A second Req_Valid held high through RESP SHALL be accepted on the first edge after the return to IDLE, never earlier.

Reset
REQ-036 While Reset_N=0, the FSM SHALL be IDLE and the outputs SHALL be: Req_Ready=1, Rsp_Valid=0, Rsp_Fault=0, Rsp_RData=0, Mem_Addr=0, Mem_En_W=0, Mem_En_R=0, Mem_Data_W=0.
REQ-037 A reset asserted mid-operation SHALL drop Mem_En_W and Mem_En_R immediately, with no Rsp_Valid for the aborted request.
REQ-038 After reset release, the first accept SHALL be possible on the first rising edge.

Verification
REQ-039 The bench SHALL cover a store: Addr 0x00000010, WData 0xDEADBEEF accepted at edge 0 -> cycle 1: Mem_En_W=1, Mem_Addr=4, Mem_Data_W=0xDEADBEEF; cycle 2: Rsp_Valid=1, Rsp_Fault=0.
REQ-040 The bench SHALL cover a load with READ_LATENCY=1: Addr 0x10 returning memory data 0xDEADBEEF -> cycle 1: Mem_En_R=1, Mem_Addr=4; cycle 2: Rsp_Valid=1, Rsp_RData=0xDEADBEEF.
REQ-041 The bench SHALL cover a load with READ_LATENCY=3 -> Rsp_Valid at cycle 4, Mem_En_R high only in cycle 1.
REQ-042 The bench SHALL cover faults: Addr 0x00000002, then Addr 0x00004000 -> each gives Rsp_Valid with Rsp_Fault=1 and Rsp_RData=0 one cycle after accept, and no memory enable.
REQ-043 The bench SHALL cover back-to-back accesses: Req_Valid held high for a store then a load -> second accept on the edge after RESP, with one Rsp_Valid per request.
REQ-044 The bench SHALL cover reset during a load: Reset_N low in the READ cycle -> Mem_En_R drops at once, no Rsp_Valid follows, and Req_Ready=1.
